// File: rtl/digi_readout_seq.sv
// digi_readout_seq - multi-channel readout sequencer.
//
// On a rising edge of eos (accepted only while idle), the pending mask and the
// per-channel sample count are latched. Every pending channel, lowest index first,
// is then streamed as one framed packet over a valid/ready word stream:
//   header  {4'hF, 0..., sel}
//   N data  {sample, 0...}  (left-justified)
//   trailer {4'hE, 0..., xor of samples}  (only with DIGI_TRAILER_EN defined)
//
// Optional build macro: DIGI_TRAILER_EN (adds the checksum trailer word).
//
// Ports:
//   CLK, RST     clock; synchronous active-high reset
//   eos          end-of-sample level; its rising edge starts a readout
//   ch_en        channel enable mask, latched on an accepted eos edge
//   how_many     samples per channel, latched on an accepted eos edge
//   ch_data      FWFT head sample per channel, ch i at [i*WIDTH +: WIDTH]
//   ch_rd_req    one-hot pop strobe, asserted only on a data word transfer
//   ch_trigger   channels still waiting to be read out
//   dout         stream word; dout_valid/dout_ready handshake
//   busy         high from accepted eos until the done cycle ends
//   done         single-cycle pulse once all channels are read out
module digi_readout_seq #(
  parameter int CHAN  = 8,
  parameter int WIDTH = 12,
  parameter int OUT_W = 16,
  parameter int CNT_W = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  eos,
  input  logic [CHAN-1:0]       ch_en,
  input  logic [CNT_W-1:0]      how_many,
  input  logic [CHAN*WIDTH-1:0] ch_data,
  output logic [CHAN-1:0]       ch_rd_req,
  output logic [CHAN-1:0]       ch_trigger,
  output logic [OUT_W-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int SEL_W = $clog2(CHAN);

`ifdef DIGI_TRAILER_EN
  typedef enum logic [2:0] {IDLE, SELECT, HEADER, DATA, CLEAR, DONE, TRAILER} state_t;
  localparam state_t PKT_END = TRAILER;
`else
  typedef enum logic [2:0] {IDLE, SELECT, HEADER, DATA, CLEAR, DONE} state_t;
  localparam state_t PKT_END = CLEAR;
`endif

  state_t           state;
  logic             eos_q;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] low_idx;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] cnt_lim;
  logic [WIDTH-1:0] cur_sample;
  logic             xfer;
  logic             last_sample;
`ifdef DIGI_TRAILER_EN
  logic [WIDTH-1:0] xsum;
`endif

  // Stream words are decoded from the registered state; data words pass the
  // FWFT head straight through so a pop shows its successor on the next cycle.
`ifdef DIGI_TRAILER_EN
  assign dout_valid = (state == HEADER) || (state == DATA) || (state == TRAILER);
`else
  assign dout_valid = (state == HEADER) || (state == DATA);
`endif
  assign xfer        = dout_valid & dout_ready;
  assign ch_rd_req   = (state == DATA && xfer) ? (CHAN'(1) << sel) : '0;
  assign last_sample = (sample_cnt == cnt_lim - CNT_W'(1));

  always_comb begin
    cur_sample = '0;
    for (int unsigned i = 0; i < CHAN; i++)
      if (SEL_W'(i) == sel) cur_sample = ch_data[i*WIDTH +: WIDTH];
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < CHAN; i++)
      if (ch_trigger[i] && !found) begin
        low_idx = SEL_W'(i);
        found   = 1'b1;
      end
  end

  always_comb begin
    dout = '0;
    case (state)
      HEADER: begin
        dout[OUT_W-1 -: 4] = 4'hF;
        dout[SEL_W-1:0]    = sel;
      end
      DATA:    dout[OUT_W-1 -: WIDTH] = cur_sample;
`ifdef DIGI_TRAILER_EN
      TRAILER: begin
        dout[OUT_W-1 -: 4] = 4'hE;
        dout[WIDTH-1:0]    = xsum;
      end
`endif
      default: dout = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      eos_q      <= 1'b0;
      sel        <= '0;
      sample_cnt <= '0;
      cnt_lim    <= '0;
      ch_trigger <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DIGI_TRAILER_EN
      xsum       <= '0;
`endif
    end else begin
      eos_q <= eos;
      case (state)
        IDLE: begin
          if (eos && !eos_q) begin
            ch_trigger <= ch_en;
            cnt_lim    <= how_many;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (ch_trigger == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sel        <= low_idx;
            sample_cnt <= '0;
`ifdef DIGI_TRAILER_EN
            xsum       <= '0;
`endif
            state      <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state <= (cnt_lim == '0) ? PKT_END : DATA;
        end
        DATA: begin
          if (xfer) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
`ifdef DIGI_TRAILER_EN
            xsum       <= xsum ^ cur_sample;
`endif
            if (last_sample) state <= PKT_END;
          end
        end
`ifdef DIGI_TRAILER_EN
        TRAILER: begin
          if (xfer) state <= CLEAR;
        end
`endif
        CLEAR: begin
          ch_trigger[sel] <= 1'b0;
          state           <= SELECT;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digi_readout_seq.sv
// Testbench for digi_readout_seq: FWFT channel buffer model plus a word scoreboard.
module tb_digi_readout_seq;
  localparam int CHAN  = 8;
  localparam int WIDTH = 12;
  localparam int OUT_W = 16;
  localparam int CNT_W = 12;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  eos = 1'b0;
  logic [CHAN-1:0]       ch_en = '0;
  logic [CNT_W-1:0]      how_many = '0;
  logic [CHAN*WIDTH-1:0] ch_data = '0;
  logic [CHAN-1:0]       ch_rd_req;
  logic [CHAN-1:0]       ch_trigger;
  logic [OUT_W-1:0]      dout;
  logic                  dout_valid;
  logic                  dout_ready = 1'b0;
  logic                  busy;
  logic                  done;

  always #5 CLK = ~CLK;

  digi_readout_seq #(.CHAN(CHAN), .WIDTH(WIDTH), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .eos(eos), .ch_en(ch_en), .how_many(how_many),
    .ch_data(ch_data), .ch_rd_req(ch_rd_req), .ch_trigger(ch_trigger),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [WIDTH-1:0] chq [CHAN][$];
  logic [OUT_W-1:0] exp_q[$];
  logic [CHAN-1:0]  trig_seen[$];
  logic [CHAN-1:0]  last_trig = '0;
  logic [CHAN-1:0]  pend;
  logic [OUT_W-1:0] prev_dout = '0;
  logic [OUT_W-1:0] last_trailer = '0;
  bit               mon_en = 1'b1;
  bit               hold_prev = 1'b0;
  int               rdy_mode = 0;
  int               done_cnt = 0;
  int               last_hdr = -1;
  int               run_id = 0;

  task automatic refresh();
    for (int i = 0; i < CHAN; i++)
      ch_data[i*WIDTH +: WIDTH] = (chq[i].size() != 0) ? chq[i][0] : '0;
  endtask

  task automatic monitor();
    logic [OUT_W-1:0] e;
    if (ch_rd_req != '0) begin
      check("rdreq_xfer", 32'(dout_valid & dout_ready), 32'd1);
      check("rdreq_onehot", 32'($onehot(ch_rd_req)), 32'd1);
    end
    if (hold_prev) begin
      check("hold_valid", 32'(dout_valid), 32'd1);
      check("hold_dout", 32'(dout), 32'(prev_dout));
    end
    hold_prev = dout_valid & ~dout_ready & ~RST;
    prev_dout = dout;
    if (mon_en && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(dout), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        check("word", 32'(dout), 32'(e));
      end
      check("busy_run", 32'(busy), 32'd1);
      if (dout[15:12] == 4'hF) last_hdr = int'(dout[2:0]);
      if (dout[15:12] == 4'hE) last_trailer = dout;
    end
    if (done) done_cnt++;
    if (ch_trigger !== last_trig) begin
      trig_seen.push_back(ch_trigger);
      last_trig = ch_trigger;
    end
  endtask

  // One clock: drive ready at negedge, observe, then apply buffer pops after posedge.
  task automatic step();
    logic [WIDTH-1:0] tmp;
    @(negedge CLK);
    dout_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    monitor();
    pend = ch_rd_req;
    @(posedge CLK);
    #1;
    for (int i = 0; i < CHAN; i++)
      if (pend[i]) begin
        if (chq[i].size() == 0) check("pop_underflow", 32'(i), 32'hFFFF_FFFF);
        else tmp = chq[i].pop_front();
      end
    refresh();
  endtask

  task automatic build_exp(input logic [CHAN-1:0] en);
    logic [WIDTH-1:0] xs;
    for (int i = 0; i < CHAN; i++)
      if (en[i]) begin
        exp_q.push_back(16'hF000 | OUT_W'(i));
        xs = '0;
        foreach (chq[i][k]) begin
          exp_q.push_back({chq[i][k], 4'h0});
          xs = xs ^ chq[i][k];
        end
`ifdef DIGI_TRAILER_EN
        exp_q.push_back({4'hE, xs});
`endif
      end
  endtask

  task automatic load(input int hm);
    run_id++;
    for (int i = 0; i < CHAN; i++) begin
      chq[i].delete();
      for (int k = 0; k < hm; k++) chq[i].push_back(WIDTH'(run_id * 37 + i * 16 + k * 3));
    end
    refresh();
  endtask

  task automatic run(input logic [CHAN-1:0] en, input int hm);
    int n;
    int rem [CHAN];
    build_exp(en);
    for (int i = 0; i < CHAN; i++) rem[i] = en[i] ? 0 : int'(chq[i].size());
    done_cnt = 0;
    trig_seen.delete();
    last_trig = ch_trigger;
    ch_en = en;
    how_many = CNT_W'(hm);
    eos = 1'b1;
    step();
    step();
    check("busy_start", 32'(busy), 32'd1);
    eos = 1'b0;
    ch_en = ~en;                       // must be ignored until the next edge
    how_many = CNT_W'(hm + 3);
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      step();
      n++;
    end
    check("done_seen", 32'(done_cnt != 0), 32'd1);
    step();
    step();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < CHAN; i++) check("buf_left", 32'(chq[i].size()), 32'(rem[i]));
  endtask

  logic [CHAN-1:0] exp_tr [4];
  int n5;

  initial begin
    exp_tr[0] = 8'hA4; exp_tr[1] = 8'hA0; exp_tr[2] = 8'h80; exp_tr[3] = 8'h00;

    // reset state
    RST = 1'b1;
    step(); step(); step();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig", 32'(ch_trigger), 32'd0);
    check("rst_rdreq", 32'(ch_rd_req), 32'd0);
    RST = 1'b0;
    step();

    // all channels, 4 samples, ready held high
    load(4);
    run(8'hFF, 4);

    // sparse mask; trigger mask must shrink bit by bit
    load(2);
    run(8'hA4, 2);
    check("trig_steps", 32'(trig_seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < trig_seen.size()) check("trig_val", 32'(trig_seen[i]), 32'(exp_tr[i]));

    // random backpressure
    rdy_mode = 1;
    load(3);
    run(8'hFF, 3);
    rdy_mode = 0;

    // zero samples per channel: header (and trailer) only, no pops
    load(0);
    run(8'h03, 0);

    // second eos during ch3 is ignored; reset during ch5 data abandons the run
    load(4);
    build_exp(8'hFF);
    last_hdr = -1;
    ch_en = 8'hFF;
    how_many = CNT_W'(4);
    eos = 1'b1;
    step(); step();
    eos = 1'b0;
    n5 = 0;
    while (last_hdr != 3 && n5 < 2000) begin step(); n5++; end
    check("reach_ch3", 32'(last_hdr), 32'd3);
    eos = 1'b1;
    step(); step();
    eos = 1'b0;
    while (last_hdr != 5 && n5 < 2000) begin step(); n5++; end
    check("reach_ch5", 32'(last_hdr), 32'd5);
    step(); step();
    RST = 1'b1;
    mon_en = 1'b0;
    step();
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_rdreq", 32'(ch_rd_req), 32'd0);
    check("mid_rst_trig", 32'(ch_trigger), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    RST = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    mon_en = 1'b1;
    step();
    load(2);
    run(8'hFF, 2);

`ifdef DIGI_TRAILER_EN
    // checksum trailer over known samples on ch0
    for (int i = 0; i < CHAN; i++) chq[i].delete();
    chq[0].push_back(12'h123);
    chq[0].push_back(12'h456);
    chq[0].push_back(12'h789);
    refresh();
    run(8'h01, 3);
    check("trailer_xsum", 32'(last_trailer), 32'h0000_E2FC);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
